c_pipe_stage_reg: RTL and testbench
===================================

# c_pipe_stage_reg

Parametrised control/data pipeline stage register: one pipeline boundary (e.g. ID/EX, EX/MEM) with a valid/ready handshake, synchronous flush to a configurable NOP payload, and an optional skid entry that breaks the combinational ready path. It replaces the hand-written per-boundary control registers. A single module is instantiated once per boundary with `WIDTH` sized to the packed control bundle of that boundary.

## Interface
Parameters:
- `WIDTH`, 8: payload width in bits; must be ≥1.
- `NOP_VAL`, `'0` (`WIDTH` bits): payload presented on reset, on flush and whenever the output is invalid.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous flush: drop all held and incoming beats.
- `valid_i`  in  1  upstream beat valid.
- `ready_o`  out  1  stage can accept a beat this cycle.
- `data_i`  in  `WIDTH`  upstream payload.
- `valid_o`  out  1  downstream beat valid.
- `ready_i`  in  1  downstream accepts; a stall is `ready_i`=0.
- `data_o`  out  `WIDTH`  downstream payload; `NOP_VAL` when `valid_o`=0.
- `occ_o`  out  2  number of held entries (0..2).

## Operation
- Transfer in: `valid_i && ready_o`. Transfer out: `valid_o && ready_i`.
- Main entry (`main_v`, `main_d`) drives `valid_o`/`data_o`. The skid entry (`skid_v`, `skid_d`) exists only with `PIPE_SKID_EN`.
- Without skid:
  - `ready_o = !main_v || ready_i`, which is combinational from `ready_i`.
  - On transfer in, the main entry loads `data_i`. If out without in, `main_v` clears.
- With skid:
  - `ready_o = !skid_v`, driven from a register only.
  - Transfer in while main is empty, or while the main entry drains: load main. The source is the skid entry if `skid_v`, else `data_i`.
  - Transfer in while main is full and `ready_i`=0: load skid.
  - Transfer out while `skid_v`: skid moves to main. Skid then takes `data_i` if a transfer in also occurs, else it clears.
  - Order is strictly preserved. There is no bypass from `data_i` to `data_o` in the same cycle.
- Flush:
  - `flush_i` clears `main_v` and `skid_v` and sets both payloads to `NOP_VAL`.
  - It dominates every simultaneous transfer. An incoming beat in the flush cycle is discarded; upstream treats it as consumed.
- Payload registers load only on a transfer. A held entry is stable while `ready_i`=0.
- `occ_o = main_v + skid_v`. Without skid, `occ_o[1]` is always 0.

## Timing
- Reset (async assert, released synchronously by the system):
  - `main_v`=`skid_v`=0 and `valid_o`=0.
  - `data_o`=`NOP_VAL` and `occ_o`=0.
  - `ready_o`=1 with skid; without skid, `ready_o`=1 because `main_v`=0.
- Latency is 1 cycle from transfer in to `valid_o` for a beat entering an empty stage.
- Throughput is 1 beat/cycle while `ready_i`=1.
- With skid, `ready_o` falls one cycle after the first stall cycle that receives a beat. At most one extra beat is absorbed.
- Reset mid-operation: all held beats are lost immediately, whatever the state of `clk`.
- Flush asserted during a stall: `valid_o`=0 next cycle, even while `ready_i`=0.
- A `NOP_VAL` payload with `valid_o`=1 is legal; only `valid_o` qualifies a beat.

## Configuration
- Macro: `C_PIPE_SKID_EN`.
- Defined: the skid entry is compiled in, `ready_o` is registered, and `occ_o` can reach 2.
- Undefined: single entry, `ready_o` is combinational from `ready_i`, and no skid registers are generated.

## Structure
- Package `c_pipe_pkg`:
  - Packed bundle typedefs per boundary, e.g. `id_ex_ctrl_t` with regwe_e, regwe_w, opb_src, mem_write, branch, jump, ex_path[1:0], alu_func[2:0].
  - Their NOP constants, e.g. `ID_EX_CTRL_NOP` with opb_src=1 and all others 0.
- Sub-module `c_pipe_slot`: one valid+payload entry with load, clear (flush) and async reset to `NOP_VAL`. It is instantiated once for main and once for skid.

## Test plan
- Reset with `NOP_VAL`=8'hA5 → `valid_o`=0, `data_o`=8'hA5, `occ_o`=0, `ready_o`=1.
- Streaming with `ready_i`=1 and beats 01,02,03 on consecutive cycles → `data_o` shows 01,02,03 one cycle later each, with no bubbles.
- Skid enabled, beat 10 held, `ready_i`=0, beat 11 offered → `occ_o`=2, then `ready_o`=0. On release, the order out is 10 then 11.
- Skid disabled, beat 20 held, `ready_i`=0 → `ready_o`=0 in the same cycle and `data_o` stays 20.
- Flush with `occ_o`=2 plus a simultaneous `valid_i` beat 30 → next cycle `valid_o`=0, `occ_o`=0, `data_o`=`NOP_VAL`, and 30 is never output.
- Async `reset` pulse between clock edges while holding a beat → `valid_o` drops before the next edge and `data_o`=`NOP_VAL`.

Source files
------------

// File: rtl/c_pipe_pkg.sv
// rtl/c_pipe_pkg.sv - control bundle types, NOP constants and helpers for pipeline stage registers
package c_pipe_pkg;

  typedef struct packed {
    logic       regwe_e;
    logic       regwe_w;
    logic       opb_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] ex_path;
    logic [2:0] alu_func;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '{
    regwe_e:   1'b0,
    regwe_w:   1'b0,
    opb_src:   1'b1,
    mem_write: 1'b0,
    branch:    1'b0,
    jump:      1'b0,
    ex_path:   2'b00,
    alu_func:  3'b000
  };

  typedef struct packed {
    logic regwe_w;
    logic mem_write;
    logic mem_read;
  } ex_mem_ctrl_t;

  localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '{regwe_w: 1'b0, mem_write: 1'b0, mem_read: 1'b0};

  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/c_pipe_slot.sv
// rtl/c_pipe_slot.sv - one valid+payload entry with load, drop, flush clear and async reset to NOP_VAL
module c_pipe_slot
  import c_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             v,
  output logic [WIDTH-1:0] q
);

  // Payload only changes on load or clear, so a held beat is stable through stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= 1'b0;
      q <= NOP_VAL;
    end else if (clear) begin
      v <= 1'b0;
      q <= NOP_VAL;
    end else if (load) begin
      v <= 1'b1;
      q <= d;
    end else if (drop) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/c_pipe_stage_reg.sv
// rtl/c_pipe_stage_reg.sv - valid/ready pipeline boundary register with flush to NOP_VAL
// rtl/c_pipe_stage_reg.sv - optional skid entry (registered ready_o) under C_PIPE_SKID_EN
module c_pipe_stage_reg
  import c_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             main_load;
  logic             main_drop;
  logic [WIDTH-1:0] main_src;
  logic             xfer_in;
  logic             xfer_out;

  assign xfer_in  = valid_i && ready_o;
  assign xfer_out = main_v && ready_i;

`ifdef C_PIPE_SKID_EN
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;
  logic             skid_load;
  logic             skid_drop;

  assign ready_o = !skid_v;

  // Skid always refills main ahead of new input so beat order is preserved.
  assign main_load = (skid_v && xfer_out) ||
                     (xfer_in && !skid_v && (!main_v || xfer_out));
  assign main_src  = skid_v ? skid_d : data_i;
  assign skid_load = xfer_in && ((main_v && !xfer_out) || (skid_v && xfer_out));
  assign skid_drop = skid_v && xfer_out && !xfer_in;

  c_pipe_slot #(
    .WIDTH   (WIDTH),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (flush_i),
    .load  (skid_load),
    .drop  (skid_drop),
    .d     (data_i),
    .v     (skid_v),
    .q     (skid_d)
  );

  assign occ_o = occ_count(main_v, skid_v);
`else
  assign ready_o   = !main_v || ready_i;
  assign main_load = xfer_in;
  assign main_src  = data_i;
  assign occ_o     = occ_count(main_v, 1'b0);
`endif

  assign main_drop = xfer_out && !main_load;

  c_pipe_slot #(
    .WIDTH   (WIDTH),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (flush_i),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_src),
    .v     (main_v),
    .q     (main_d)
  );

  assign valid_o = main_v;
  assign data_o  = main_v ? main_d : NOP_VAL;

endmodule

// File: tb/tb_c_pipe_stage_reg.sv
// tb/tb_c_pipe_stage_reg.sv - directed and scoreboard bench for c_pipe_stage_reg, either C_PIPE_SKID_EN build
module tb_c_pipe_stage_reg;

  localparam logic [7:0] NOP = 8'hA5;

  logic       clk;
  logic       reset;
  logic       flush_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic [1:0] occ_o;

  int         tests;
  int         fails;
  logic [7:0] q[$];

  c_pipe_stage_reg #(
    .WIDTH   (8),
    .NOP_VAL (NOP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .occ_o   (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, score transfers mid-cycle, advance past the edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    logic [8:0] exp9;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (valid_o && ready_i) begin
        exp9 = (q.size() > 0) ? {1'b0, q.pop_front()} : 9'h100;
        chk("sb_data_out", {23'd0, 1'b0, data_o}, {23'd0, exp9});
      end
      if (valid_i && ready_o) q.push_back(data_i);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = 8'h00;

    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, NOP);
    chk("rst_occ", occ_o, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back stream, no bubbles
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    chk("stream_v1", valid_o, 1);
    chk("stream_d1", data_o, 8'h01);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    chk("stream_v2", valid_o, 1);
    chk("stream_d2", data_o, 8'h02);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    chk("stream_v3", valid_o, 1);
    chk("stream_d3", data_o, 8'h03);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_idle_v", valid_o, 0);
    chk("stream_idle_d", data_o, NOP);

`ifdef C_PIPE_SKID_EN
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    chk("skid_occ1", occ_o, 1);
    chk("skid_ready1", ready_o, 1);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    chk("skid_occ2", occ_o, 2);
    chk("skid_ready0", ready_o, 0);
    chk("skid_hold_d", data_o, 8'h10);
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    chk("skid_full_occ", occ_o, 2);
    chk("skid_full_d", data_o, 8'h10);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("skid_rel_d", data_o, 8'h11);
    chk("skid_rel_occ", occ_o, 1);
    chk("skid_rel_ready", ready_o, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("skid_empty_occ", occ_o, 0);

    drive(1'b1, 8'h40, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    chk("flush_pre_occ", occ_o, 2);
`else
    drive(1'b1, 8'h20, 1'b1, 1'b0);
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("noskid_ready_comb0", ready_o, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("noskid_hold_v", valid_o, 1);
    chk("noskid_hold_d", data_o, 8'h20);
    chk("noskid_occ", occ_o, 1);
    ready_i = 1'b1;
    #1;
    chk("noskid_ready_comb1", ready_o, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    drive(1'b1, 8'h40, 1'b0, 1'b0);
    chk("flush_pre_occ", occ_o, 1);
`endif

    // Flush during a stall with a simultaneous incoming beat
    drive(1'b1, 8'h30, 1'b0, 1'b1);
    chk("flush_valid", valid_o, 0);
    chk("flush_occ", occ_o, 0);
    chk("flush_data", data_o, NOP);
    chk("flush_ready", ready_o, 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_no30_a", valid_o, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_no30_b", valid_o, 0);

    // Async reset pulse between edges while holding a beat
    drive(1'b1, 8'h50, 1'b0, 1'b0);
    chk("arst_pre_v", valid_o, 1);
    valid_i = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_data", data_o, NOP);
    chk("arst_occ", occ_o, 0);
    q.delete();
    #1;
    reset = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      if (q.size() > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("sb_drain_empty", q.size(), 0);
    chk("sb_drain_valid", valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
